// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory front end.
// Contents: access-size encoding, default memory size, size-to-byte-enable
// and size-to-byte-count decoders.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;

  // Byte lanes touched by an access; illegal size enables nothing.
  function automatic logic [3:0] size_to_byt_en(input logic [1:0] size);
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b0001;
      SZ_HALF: en = 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Bytes covered by an access; illegal size is flagged separately, so its
  // count only needs to be harmless in the range check.
  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arbiter.sv
// Round-robin arbiter over N_REQ eligible requesters.
// Ports: clk, rst_n (async active-low), eligible (request vector),
//        grant_c (one-hot or zero, combinational from eligible and pointer).
// The pointer names the highest-priority port and moves past each winner.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] eligible,
  output logic [N_REQ-1:0] grant_c
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;
  logic          found;

  // Scan ports starting at the pointer, first eligible one wins.
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    gidx    = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PW'((32'(ptr) + k) % N_REQ);
      if (!found && eligible[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        gidx         = idx;
      end
    end
  end

  // Pointer moves to the port after the winner; holds when idle.
  always_comb begin
    ptr_next = ptr;
    if (found) begin
      ptr_next = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-requester front end for the byte-enable data memory.
// Ports: clk, rst_n; per-requester req_* (valid/ready request channel with
//        we/size/signed/addr/wdata) and rsp_* (valid/ready response with
//        rdata/err); mem_* drive the memory combinationally in the grant
//        cycle, mem_rd_data is its combinational read data.
// One access per cycle; the response registers one cycle after grant.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_we,
  input  logic [N_REQ-1:0][1:0]  req_size,
  input  logic [N_REQ-1:0]       req_signed,
  input  logic [N_REQ-1:0][31:0] req_addr,
  input  logic [N_REQ-1:0][31:0] req_wdata,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [N_REQ-1:0][31:0] rsp_rdata,
  output logic [N_REQ-1:0]       rsp_err,
  output logic [31:0]            mem_adrs_rd,
  output logic [31:0]            mem_adrs_wr,
  output logic                   mem_wr_en,
  output logic [3:0]             mem_byt_en,
  output logic                   mem_sign_ext,
  output logic [31:0]            mem_wr_data,
  input  logic [31:0]            mem_rd_data
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gsel;
  logic             any_grant;
  logic             sel_we;
  logic [1:0]       sel_size;
  logic             sel_signed;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_byt_en;
  logic [32:0]      end_addr;
  logic             sel_err;

  // A port may win only if its response slot is free or draining now.
  assign eligible = req_valid & (~rsp_valid | rsp_ready);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant_c  (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  // One-hot grant to index.
  always_comb begin
    gsel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) gsel = IW'(i);
    end
  end

  assign sel_we     = req_we[gsel];
  assign sel_size   = req_size[gsel];
  assign sel_signed = req_signed[gsel];
  assign sel_addr   = req_addr[gsel];
  assign sel_wdata  = req_wdata[gsel];
  assign sel_byt_en = size_to_byt_en(sel_size);

  // Last byte computed in 33 bits so addresses near 2^32 cannot wrap legal.
  assign end_addr = {1'b0, sel_addr} + 33'(size_to_nbytes(sel_size)) - 33'd1;
  assign sel_err  = (sel_size == SZ_ILL) || (end_addr > 33'(MEM_BYTES - 1));

  // Memory drive: idle and rejected grants leave every control at zero.
  always_comb begin
    mem_adrs_rd  = '0;
    mem_adrs_wr  = '0;
    mem_wr_en    = 1'b0;
    mem_byt_en   = '0;
    mem_sign_ext = 1'b0;
    mem_wr_data  = '0;
    if (any_grant && !sel_err) begin
      mem_byt_en = sel_byt_en;
      if (sel_we) begin
        mem_adrs_wr = sel_addr;
        mem_wr_data = sel_wdata;
        mem_wr_en   = 1'b1;
      end else begin
        mem_adrs_rd  = sel_addr;
        mem_sign_ext = sel_signed;
      end
    end
  end

  // Response slots: a new grant reloads even while draining, else drain clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_rdata[i] <= (sel_err || sel_we) ? '0 : mem_rd_data;
          rsp_err[i]   <= sel_err;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
          rsp_rdata[i] <= '0;
          rsp_err[i]   <= 1'b0;
        end
      end
    end
  end

endmodule
